// File: rtl/qc_ldpc_syndrome_accum.sv
// qc_ldpc_syndrome_accum: runtime-selectable-Z QC-LDPC parity accumulation engine.
// Streams NUM_INFO_BLKS info blocks in, XORs cyclically rotated copies into
// NUM_PARITY_BLKS row accumulators using the shift table for the selected Z,
// then streams the row sums out.
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   en_i                   global enable, 0 freezes all state and gates the valid/ready outputs
//   start_i, req_z_i       frame start request and one-hot lifting-size select (sampled in IDLE)
//   busy_o, err_z_o        not-IDLE flag, one-cycle pulse on start with non-one-hot req_z_i
//   in_valid_i/in_ready_o  info block handshake, in_data_i carries the block (bits >= Z ignored)
//   out_valid_o/out_ready_i row sum handshake, out_data_o/out_idx_o/out_last_o describe the row
module qc_ldpc_syndrome_accum #(
    parameter int NUM_Z           = 3,
    parameter int MAX_Z           = 81,
    parameter int NUM_INFO_BLKS   = 20,
    parameter int NUM_PARITY_BLKS = 4,
    parameter int Z_VALUES [NUM_Z] = '{27, 54, 81},
    parameter int SHIFT_TABLE [NUM_Z*NUM_PARITY_BLKS*NUM_INFO_BLKS] = '{default: -1}
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               en_i,
    input  logic                               start_i,
    input  logic [NUM_Z-1:0]                   req_z_i,
    output logic                               busy_o,
    output logic                               err_z_o,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [MAX_Z-1:0]                   in_data_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [MAX_Z-1:0]                   out_data_o,
    output logic [$clog2(NUM_PARITY_BLKS)-1:0] out_idx_o,
    output logic                               out_last_o
);
    localparam int ZW = NUM_Z > 1 ? $clog2(NUM_Z) : 1;
    localparam int CW = NUM_INFO_BLKS > 1 ? $clog2(NUM_INFO_BLKS) : 1;
    localparam int RW = $clog2(NUM_PARITY_BLKS);
    localparam int TN = NUM_Z * NUM_PARITY_BLKS * NUM_INFO_BLKS;
    localparam int TW = $clog2(TN);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t           state_q;
    logic [ZW-1:0]    zsel_q, zsel_d;
    logic [CW-1:0]    col_q;
    logic [RW-1:0]    row_q;
    logic [MAX_Z-1:0] acc_q [NUM_PARITY_BLKS];
    logic [MAX_Z-1:0] acc_d [NUM_PARITY_BLKS];
    logic [MAX_Z-1:0] out_data_q, zmask, xm;
    logic             busy_q, err_q, in_rdy_q, out_vld_q, out_last_q;
    int               zlen, s;

    assign busy_o      = busy_q;
    assign err_z_o     = err_q;
    assign in_ready_o  = in_rdy_q & en_i;
    assign out_valid_o = out_vld_q & en_i;
    assign out_data_o  = out_data_q;
    assign out_idx_o   = row_q;
    assign out_last_o  = out_last_q;

    always_comb begin
        zsel_d = '0;
        for (int i = 0; i < NUM_Z; i++)
            if (req_z_i[i]) zsel_d = ZW'(i);
    end

    // Rotation within Z bits: the left shift keeps bits that stay below Z, the right
    // shift by Z-s brings the wrapped bits back in; s == 0 makes the right shift clear all.
    always_comb begin
        s     = 0;
        zlen  = Z_VALUES[zsel_q];
        zmask = {MAX_Z{1'b1}} >> (MAX_Z - zlen);
        xm    = in_data_i & zmask;
        for (int r = 0; r < NUM_PARITY_BLKS; r++) begin
            s = SHIFT_TABLE[TW'((int'(zsel_q) * NUM_PARITY_BLKS + r) * NUM_INFO_BLKS + int'(col_q))];
            acc_d[r] = (s < 0) ? acc_q[r] : acc_q[r] ^ (((xm << s) | (xm >> (zlen - s))) & zmask);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            zsel_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            acc_q      <= '{default: '0};
            out_data_q <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            in_rdy_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
        end else if (en_i) begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    if ($onehot(req_z_i)) begin
                        zsel_q   <= zsel_d;
                        acc_q    <= '{default: '0};
                        col_q    <= '0;
                        busy_q   <= 1'b1;
                        in_rdy_q <= 1'b1;
                        state_q  <= ACCUM;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                ACCUM: if (in_valid_i) begin
                    acc_q <= acc_d;
                    col_q <= col_q + 1'b1;
                    if (col_q == CW'(NUM_INFO_BLKS - 1)) begin
                        col_q      <= '0;
                        row_q      <= '0;
                        in_rdy_q   <= 1'b0;
                        out_vld_q  <= 1'b1;
                        out_data_q <= acc_d[0];
                        out_last_q <= (NUM_PARITY_BLKS == 1);
                        state_q    <= DRAIN;
                    end
                end
                DRAIN: if (out_ready_i) begin
                    if (out_last_q) begin
                        row_q      <= '0;
                        out_vld_q  <= 1'b0;
                        out_data_q <= '0;
                        out_last_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        row_q      <= RW'(row_q + 1'b1);
                        out_data_q <= acc_q[RW'(row_q + 1'b1)];
                        out_last_q <= (RW'(row_q + 1'b1) == RW'(NUM_PARITY_BLKS - 1));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i)
        if (rst_ni && en_i && state_q == IDLE && start_i && $onehot(req_z_i))
            assert (req_z_i[zsel_d]) else $error("accepted start with malformed req_z");

    for (genvar z = 0; z < NUM_Z; z++) begin : g_zchk
        always_ff @(posedge clk_i)
            assert (Z_VALUES[z] >= 1 && Z_VALUES[z] <= MAX_Z) else $error("Z_VALUES[%0d] out of range", z);
    end

    for (genvar t = 0; t < TN; t++) begin : g_tchk
        always_ff @(posedge clk_i)
            assert (SHIFT_TABLE[t] >= -1 && SHIFT_TABLE[t] < Z_VALUES[t / (NUM_PARITY_BLKS * NUM_INFO_BLKS)])
                else $error("SHIFT_TABLE[%0d] out of range", t);
    end
endmodule
